// File: rtl/iir_pkg.sv
// Shared types and constants for the multi-channel biquad: FSM encoding,
// coefficient slot indices, accumulator sizing and saturation limits.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam int NCOEF = 5;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // Five products of |x| <= 2^(DW-1), |c| <= 2^(CW-1) fit with 3 guard bits.
    function automatic int acc_w(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    function automatic longint sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared signed multiply-accumulate with clear/enable/subtract, followed by
// combinational round-half-up and saturation back to the sample width.
module iir_mac_sat
    import iir_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = acc_w(DW, CW)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 sub,
    input  logic signed [DW-1:0] a,
    input  logic signed [CW-1:0] b,
    output logic signed [DW-1:0] y_sat,
    output logic                 clip
);

    localparam int PW   = DW + CW;
    localparam int FRAC = CW - 2;
    localparam logic signed [AW-1:0] Y_MAX = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] Y_MIN = AW'(sat_min(DW));
    localparam logic signed [AW-1:0] HALF  = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

    logic signed [PW-1:0] a_ext, b_ext, prod;
    logic signed [AW-1:0] prod_ext, acc;

    function automatic logic signed [AW-1:0] round_acc(input logic signed [AW-1:0] v);
        return (v + HALF) >>> FRAC;
    endfunction

    // Returns {clip, value}.
    function automatic logic [DW:0] sat_acc(input logic signed [AW-1:0] v);
        logic [DW:0] r;
        if (v > Y_MAX)
            r = {1'b1, Y_MAX[DW-1:0]};
        else if (v < Y_MIN)
            r = {1'b1, Y_MIN[DW-1:0]};
        else
            r = {1'b0, v[DW-1:0]};
        return r;
    endfunction

    assign a_ext    = {{CW{a[DW-1]}}, a};
    assign b_ext    = {{DW{b[CW-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

    // Accumulator stage: cleared on accept, one product per enabled cycle.
    always_ff @(posedge clk) begin
        if (clr)
            acc <= '0;
        else if (en)
            acc <= sub ? acc - prod_ext : acc + prod_ext;
    end

    assign {clip, y_sat} = sat_acc(round_acc(acc));

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel Direct Form I biquad: one MAC serves NCH
// channels, 7 cycles per sample, run-time programmable coefficients.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int DW  = 16,
    parameter int CW  = 16,
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x,
    input  logic [CHW-1:0]       x_ch,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 hist_clr,
    input  logic                 flag_clr,
    output logic signed [DW-1:0] y,
    output logic [CHW-1:0]       y_ch,
    output logic                 y_valid,
    output logic                 sat_flag,
    output logic                 ch_err
);

    localparam logic signed [CW-1:0] ONE = {2'b01, {(CW-2){1'b0}}};

    state_t state, state_nx;
    logic [2:0] k;

    logic signed [CW-1:0] coef [NCOEF];
    logic signed [CW-1:0] snap [NCOEF];
    logic signed [DW-1:0] hx1 [NCH];
    logic signed [DW-1:0] hx2 [NCH];
    logic signed [DW-1:0] hy1 [NCH];
    logic signed [DW-1:0] hy2 [NCH];

    logic signed [DW-1:0] xs, sx1, sx2, sy1, sy2;
    logic [CHW-1:0]       chs;

    logic                 accept, ch_ok, mac_en, mac_sub, in_wb, clip;
    logic signed [DW-1:0] mac_a, y_sat;
    logic signed [CW-1:0] mac_b;

    assign x_ready = rst & (state == ST_IDLE) & ~hist_clr;
    assign accept  = x_valid & x_ready;
    assign ch_ok   = int'(x_ch) < NCH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= (state == ST_MAC) ? k + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nx = state;
        mac_en   = 1'b0;
        in_wb    = 1'b0;
        case (state)
            ST_IDLE: if (accept && ch_ok) state_nx = ST_MAC;
            ST_MAC: begin
                mac_en = 1'b1;
                if (k == 3'd4) state_nx = ST_WB;
            end
            ST_WB: begin
                in_wb    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Feedback terms use -a1, -a2, hence subtract for the last two slots.
    always_comb begin
        mac_a   = xs;
        mac_b   = snap[COEF_B0];
        mac_sub = 1'b0;
        case (k)
            3'd1: begin mac_a = sx1; mac_b = snap[COEF_B1]; end
            3'd2: begin mac_a = sx2; mac_b = snap[COEF_B2]; end
            3'd3: begin mac_a = sy1; mac_b = snap[COEF_A1]; mac_sub = 1'b1; end
            3'd4: begin mac_a = sy2; mac_b = snap[COEF_A2]; mac_sub = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) coef[i] <= (i == 0) ? ONE : '0;
        end else if (coef_we && coef_addr < 3'd5) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Accept stage: in-flight sample works on a private copy of coefs/history.
    always_ff @(posedge clk) begin
        if (accept && ch_ok) begin
            xs   <= x;
            chs  <= x_ch;
            snap <= coef;
            sx1  <= hx1[x_ch];
            sx2  <= hx2[x_ch];
            sy1  <= hy1[x_ch];
            sy2  <= hy2[x_ch];
        end
    end

    iir_mac_sat #(.DW(DW), .CW(CW)) u_mac (
        .clk   (clk),
        .clr   (accept),
        .en    (mac_en),
        .sub   (mac_sub),
        .a     (mac_a),
        .b     (mac_b),
        .y_sat (y_sat),
        .clip  (clip)
    );

    // Write-back stage: history and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                hx1[i] <= '0; hx2[i] <= '0; hy1[i] <= '0; hy2[i] <= '0;
            end
        end else if (state == ST_IDLE && hist_clr) begin
            for (int i = 0; i < NCH; i++) begin
                hx1[i] <= '0; hx2[i] <= '0; hy1[i] <= '0; hy2[i] <= '0;
            end
        end else if (in_wb) begin
            hx2[chs] <= sx1;
            hx1[chs] <= xs;
            hy2[chs] <= sy1;
            hy1[chs] <= y_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y        <= '0;
            y_ch     <= '0;
            y_valid  <= 1'b0;
            sat_flag <= 1'b0;
            ch_err   <= 1'b0;
        end else begin
            y_valid  <= in_wb;
            if (in_wb) begin
                y    <= y_sat;
                y_ch <= chs;
            end
            sat_flag <= (in_wb & clip) | (sat_flag & ~flag_clr);
            ch_err   <= (accept & ~ch_ok) | (ch_err & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc (3 channels on a 2-bit channel index so
// that an out-of-range channel can be exercised).
module tb_iir_biquad_mc;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [15:0]  x;
    logic [1:0]          x_ch;
    logic                x_valid;
    logic                x_ready;
    logic                coef_we;
    logic [2:0]          coef_addr;
    logic signed [15:0]  coef_data;
    logic                hist_clr;
    logic                flag_clr;
    logic signed [15:0]  y;
    logic [1:0]          y_ch;
    logic                y_valid;
    logic                sat_flag;
    logic                ch_err;

    int n_cmp = 0;
    int n_err = 0;

    iir_biquad_mc #(.DW(16), .CW(16), .NCH(3), .CHW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_ch      (x_ch),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .hist_clr  (hist_clr),
        .flag_clr  (flag_clr),
        .y         (y),
        .y_ch      (y_ch),
        .y_valid   (y_valid),
        .sat_flag  (sat_flag),
        .ch_err    (ch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] addr, input int val);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = 16'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic clear_hist();
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
    endtask

    task automatic accept(input int ch, input int val);
        int n = 0;
        while (!x_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", x_ready, 1);
        x_ch    = 2'(ch);
        x       = 16'(val);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_y(input string tag, input int ch, input int want);
        int n = 0;
        while (!y_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, y_valid, 1);
        check(tag, y, want);
        check({tag, "_ch"}, y_ch, ch);
    endtask

    task automatic sample(input string tag, input int ch, input int val, input int want);
        accept(ch, val);
        wait_y(tag, ch, want);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen = 1'b0;
        repeat (cycles) begin
            tick();
            if (y_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst = 1'b0; x = '0; x_ch = '0; x_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        hist_clr = 1'b0; flag_clr = 1'b0;

        repeat (3) tick();
        check("rst_y", y, 0);
        check("rst_y_ch", y_ch, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_x_ready", x_ready, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_ch_err", ch_err, 0);
        rst = 1'b1;
        tick();

        // Passthrough with cycle-exact timing: accept edge E0, output after E6.
        accept(0, 1000);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("t1_busy_ready_%0d", i), x_ready, 0);
            check($sformatf("t1_early_valid_%0d", i), y_valid, 0);
            tick();
        end
        check("t1_valid", y_valid, 1);
        check("t1_y", y, 1000);
        check("t1_y_ch", y_ch, 0);
        check("t1_ready_back", x_ready, 1);
        tick();
        check("t1_valid_one_cycle", y_valid, 0);

        // First-order decay: y = 0.5 x + 0.5 y[n-1].
        clear_hist();
        write_coef(3'd0, 8192);
        write_coef(3'd3, -8192);
        sample("t2_y0", 0, 16384, 8192);
        sample("t2_y1", 0, 0, 4096);
        sample("t2_y2", 0, 0, 2048);

        // History clear, then clear colliding with a valid sample.
        clear_hist();
        sample("t5_after_clr", 0, 16384, 8192);
        hist_clr = 1'b1; x_valid = 1'b1; x_ch = 2'd0; x = 16'sd16384;
        #1;
        check("t5_ready_during_clr", x_ready, 0);
        tick();
        hist_clr = 1'b0; x_valid = 1'b0;
        expect_quiet("t5_not_accepted", 10);
        check("t5_idle_after", x_ready, 1);

        // Channel isolation; mid-MAC coefficient write must not reach in-flight sample.
        sample("t3_ch0_a", 0, 16384, 8192);
        sample("t3_ch1_a", 1, 0, 0);
        sample("t3_ch0_b", 0, 16384, 12288);
        sample("t3_ch1_b", 1, 16384, 8192);
        accept(1, 0);
        write_coef(3'd3, 0);
        wait_y("t3_ch1_snapshot", 1, 4096);

        // Saturation and sticky flag behaviour on a fresh channel.
        check("t4_sat_idle", sat_flag, 0);
        write_coef(3'd0, 32767);
        sample("t4_pos_clip", 2, 30000, 32767);
        check("t4_sat_set", sat_flag, 1);
        sample("t4_neg_clip", 2, -30000, -32768);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("t4_sat_cleared", sat_flag, 0);
        flag_clr = 1'b1;
        sample("t4_clip_vs_clr", 2, 30000, 32767);
        flag_clr = 1'b0;
        check("t4_set_wins", sat_flag, 1);

        // Out-of-range channel is accepted and dropped.
        check("t6_ch_err_idle", ch_err, 0);
        accept(3, 1234);
        check("t6_ch_err_set", ch_err, 1);
        expect_quiet("t6_ch3_dropped", 8);
        check("t6_ready_after_drop", x_ready, 1);

        // Asynchronous reset in the middle of MAC.
        write_coef(3'd0, 8192);
        accept(0, 1000);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t6_rst_y", y, 0);
        check("t6_rst_valid", y_valid, 0);
        check("t6_rst_ready", x_ready, 0);
        check("t6_rst_sat", sat_flag, 0);
        check("t6_rst_ch_err", ch_err, 0);
        repeat (2) tick();
        rst = 1'b1;
        expect_quiet("t6_no_late_pulse", 10);
        check("t6_y_still_zero", y, 0);
        sample("t6_passthrough", 0, 500, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
